// File: rtl/alu_nibble_seq.sv
// ============================================================================
// Module      : alu_nibble_seq
// Description : Nibble-serial ALU. One 4-bit slice processes one nibble per
//               cycle, LSB first, with the carry registered between nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero
);

    localparam int c_NIB = WIDTH / 4;
    localparam int c_KW  = (c_NIB > 1) ? $clog2(c_NIB) : 1;
    localparam logic [WIDTH-1:0] c_MASK = WIDTH'(4'hF);
    localparam logic [c_KW-1:0]  c_LAST = c_KW'(c_NIB - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_NOTA = 3'b101;
    localparam logic [2:0] c_OP_PASB = 3'b110;
    localparam logic [2:0] c_OP_INC  = 3'b111;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [c_KW-1:0]  r_k;
    logic             r_carry;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_f;
    logic             r_cout;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [c_KW+1:0]  w_sh;
    logic [3:0]       w_an;
    logic [3:0]       w_bn;
    logic [3:0]       w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_work_nxt;

    // DONE is not busy, so a start seen there is accepted back-to-back
    assign w_accept = start && (r_state != c_S_RUN);
    assign w_last   = (r_k == c_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_accept) w_state_nxt = c_S_RUN;
            c_S_RUN:  if (w_last)   w_state_nxt = c_S_DONE;
            c_S_DONE: w_state_nxt = start ? c_S_RUN : c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Single 4-bit slice working on nibble r_k
    always_comb begin
        w_sh = {r_k, 2'b00};
        w_an = 4'(r_a >> w_sh);
        w_bn = 4'(r_b >> w_sh);
        w_s  = 4'h0;
        w_c  = 1'b0;
        case (r_op)
            c_OP_ADD:  {w_c, w_s} = {1'b0, w_an} + {1'b0, w_bn} + {4'b0, r_carry};
            c_OP_SUB:  {w_c, w_s} = {1'b0, w_an} + {1'b0, ~w_bn} + {4'b0, r_carry};
            c_OP_INC:  {w_c, w_s} = {1'b0, w_an} + {4'b0, r_carry};
            c_OP_AND:  w_s = w_an & w_bn;
            c_OP_OR:   w_s = w_an | w_bn;
            c_OP_XOR:  w_s = w_an ^ w_bn;
            c_OP_NOTA: w_s = ~w_an;
            c_OP_PASB: w_s = w_bn;
            default:   w_s = 4'h0;
        endcase
        w_work_nxt = (r_work & ~(c_MASK << w_sh)) | (WIDTH'(w_s) << w_sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_work  <= '0;
            r_f     <= '0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_op    <= op;
                r_k     <= '0;
                r_carry <= (op == c_OP_INC) ? 1'b1 : cin;
            end else if (r_state == c_S_RUN) begin
                r_work  <= w_work_nxt;
                r_carry <= w_c;
                r_k     <= r_k + 1'b1;
                if (w_last) begin
                    r_f    <= w_work_nxt;
                    r_cout <= w_c;
                    r_zero <= (w_work_nxt == '0);
                end
            end
        end
    end

    assign busy = (r_state == c_S_RUN);
    assign done = (r_state == c_S_DONE);
    assign f    = r_f;
    assign cout = r_cout;
    assign zero = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_nibble_seq.sv
// ============================================================================
// Module      : tb_alu_nibble_seq
// Description : Directed table-driven bench for alu_nibble_seq (WIDTH 16 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_nibble_seq;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] f;
        logic        cout;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic [2:0]  op = '0;
    logic        busy, done, cout, zero;
    logic [15:0] f;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        cin4 = 1'b0;
    logic [2:0]  op4 = '0;
    logic        busy4, done4, cout4, zero4;
    logic [3:0]  f4;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t vecs[14];

    alu_nibble_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .op(op),
        .busy(busy), .done(done), .f(f), .cout(cout), .zero(zero)
    );

    alu_nibble_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4), .op(op4),
        .busy(busy4), .done(done4), .f(f4), .cout(cout4), .zero(zero4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run16(input logic [2:0] o, input logic [15:0] va, input logic [15:0] vb,
                         input logic c, output int lat);
        @(negedge clk);
        op = o; a = va; b = vb; cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (done) lat = i;
            else chk("busy_while_running", busy, 1);
        end
        chk("done_seen", (lat != 0), 1);
        chk("busy_at_done", busy, 0);
    endtask

    task automatic run4(input logic [2:0] o, input logic [3:0] va, input logic [3:0] vb,
                        input logic c, output int lat);
        @(negedge clk);
        op4 = o; a4 = va; b4 = vb; cin4 = c; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        chk("w4_busy_after_accept", busy4, 1);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (done4) lat = i;
        end
        chk("w4_done_seen", (lat != 0), 1);
    endtask

    initial begin
        int lat;
        int ndone;

        //          op      a        b        cin   f        cout  zero
        vecs[0]  = '{3'b000, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 16'h0002, 16'h0005, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 16'h0005, 16'h0002, 1'b1, 16'h0003, 1'b1, 1'b0};
        vecs[3]  = '{3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4]  = '{3'b111, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{3'b010, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0};
        vecs[6]  = '{3'b011, 16'hF0F0, 16'h0F01, 1'b1, 16'hFFF1, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 16'h1234, 16'h0000, 1'b1, 16'hEDCB, 1'b0, 1'b0};
        vecs[9]  = '{3'b110, 16'h0000, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 1'b0};
        vecs[10] = '{3'b000, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[11] = '{3'b111, 16'h0009, 16'h0000, 1'b1, 16'h000A, 1'b0, 1'b0};
        vecs[12] = '{3'b000, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[13] = '{3'b001, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_f", f, 0);
        chk("reset_cout", cout, 0);
        chk("reset_zero", zero, 1);
        chk("w4_reset_f", f4, 0);
        chk("w4_reset_zero", zero4, 1);

        // Reset wins over a simultaneous start
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 16'h0001; b = 16'h0001;
        @(posedge clk);
        #1;
        chk("rst_over_start_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_rst_busy", busy, 0);

        for (int i = 0; i < 14; i++) begin
            run16(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            chk($sformatf("latency_v%0d", i), lat, 4);
            chk($sformatf("f_v%0d", i), f, vecs[i].f);
            chk($sformatf("cout_v%0d", i), cout, vecs[i].cout);
            chk($sformatf("zero_v%0d", i), zero, vecs[i].zero);
        end

        // Start held through busy with changing operands, then back-to-back in DONE
        @(negedge clk);
        op = 3'b100; a = 16'hA5A5; b = 16'hFFFF; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        op = 3'b000; a = 16'h1111; b = 16'h2222;
        ndone = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("held_start_done_count", ndone, 1);
        chk("held_start_done_at_4", done, 1);
        chk("held_start_f", f, 16'h5A5A);
        chk("held_start_cout", cout, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done_low", done, 0);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (done) lat = i;
        end
        chk("b2b_latency", lat, 4);
        chk("b2b_f", f, 16'h3333);

        // Reset two cycles into an ADD aborts with no done pulse
        @(negedge clk);
        op = 3'b000; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_f", f, 0);
        chk("abort_zero", zero, 1);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run16(3'b000, 16'h0F0F, 16'h0101, 1'b0, lat);
        chk("post_abort_latency", lat, 4);
        chk("post_abort_f", f, 16'h1010);
        chk("post_abort_zero", zero, 0);

        // WIDTH=4 instance
        run4(3'b000, 4'b0010, 4'b0001, 1'b0, lat);
        chk("w4_add_latency", lat, 1);
        chk("w4_add_f", f4, 4'b0011);
        chk("w4_add_cout", cout4, 0);
        run4(3'b001, 4'b0010, 4'b0101, 1'b1, lat);
        chk("w4_sub_latency", lat, 1);
        chk("w4_sub_f", f4, 4'b1101);
        chk("w4_sub_cout", cout4, 0);
        run4(3'b111, 4'b1111, 4'b0000, 1'b0, lat);
        chk("w4_inc_f", f4, 4'b0000);
        chk("w4_inc_cout", cout4, 1);
        chk("w4_inc_zero", zero4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
